// File: rtl/iq_sync_ctrl_if.sv
// ---------------------------------------------------------------------------
// iq_sync_ctrl_if
// Bundles the control/status signals between the IQ sync controller and its
// surroundings (run request, analyser status inputs, analyser control and
// lock status outputs).
//
// Signals (direction as seen by the controller, i.e. the slave modport):
//   enable       in   1   run request; low forces IDLE
//   amp_thresh   in   DW  minimum Max_Amp for a good frame
//   bits_count   in   7   analyser bit index
//   max_sync     in   3   analyser best sync phase (0..4)
//   Max_Amp      in   DW  analyser peak average amplitude
//   iq_rst       out  1   reset to analyser
//   iq_ce        out  1   clock enable to analyser
//   locked       out  1   high in LOCKED
//   lock_phase   out  3   max_sync latched at lock
//   frame_start  out  1   1-cycle pulse per frame tick while LOCKED
//   state        out  3   IDLE=0 FLUSH=1 SETTLE=2 ACQUIRE=3 LOCKED=4
//   relock_count out  8   lock-loss events, saturating
//
// Handshake: there is no valid/ready pair; inputs are level signals sampled
// every clock, outputs are registered levels (frame_start is a 1-cycle pulse).
// ---------------------------------------------------------------------------
interface iq_sync_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  enable;
   logic [DATA_WIDTH-1:0] amp_thresh;
   logic [6:0]            bits_count;
   logic [2:0]            max_sync;
   logic [DATA_WIDTH-1:0] Max_Amp;
   logic                  iq_rst;
   logic                  iq_ce;
   logic                  locked;
   logic [2:0]            lock_phase;
   logic                  frame_start;
   logic [2:0]            state;
   logic [7:0]            relock_count;

   // Environment side: drives run request and analyser status.
   modport master (
      output enable, amp_thresh, bits_count, max_sync, Max_Amp,
      input  iq_rst, iq_ce, locked, lock_phase, frame_start, state, relock_count
   );

   // Controller side.
   modport slave (
      input  enable, amp_thresh, bits_count, max_sync, Max_Amp,
      output iq_rst, iq_ce, locked, lock_phase, frame_start, state, relock_count
   );
endinterface

// File: rtl/iq_sync_ctrl.sv
// ---------------------------------------------------------------------------
// iq_sync_ctrl
// Sequencing controller for the IQ analyser. It flushes the analyser (holds
// iq_rst), lets its leaky averages settle for a number of frames, then
// acquires symbol-phase lock once max_sync is stable at adequate amplitude.
// While locked it watches for bad frames and re-flushes on lock loss.
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   ctrl_if  slave modport of iq_sync_ctrl_if (run request, analyser status
//            in; analyser reset/enable, lock status, debug state out)
// ---------------------------------------------------------------------------
module iq_sync_ctrl #(
   parameter int DATA_WIDTH    = 16,
   parameter int FRAME_BITS    = 80,
   parameter int FLUSH_CYCLES  = 4,
   parameter int SETTLE_FRAMES = 4,
   parameter int LOCK_FRAMES   = 3,
   parameter int LOSS_FRAMES   = 2
) (
   input  logic           clk,
   input  logic           rst,
   iq_sync_ctrl_if.slave  ctrl_if
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FLUSH   = 3'd1,
      S_SETTLE  = 3'd2,
      S_ACQUIRE = 3'd3,
      S_LOCKED  = 3'd4
   } state_e;

   // One counter is shared by all states (flush cycles, settle frames,
   // good-frame run, miss run); it is sized for the largest threshold so it
   // never wraps before its compare.
   localparam int MAX_AB  = (FLUSH_CYCLES > SETTLE_FRAMES) ? FLUSH_CYCLES : SETTLE_FRAMES;
   localparam int MAX_CD  = (LOCK_FRAMES > LOSS_FRAMES) ? LOCK_FRAMES : LOSS_FRAMES;
   localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [6:0]    LAST_BIT   = 7'(FRAME_BITS - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_N   = CW'(SETTLE_FRAMES);
   localparam logic [CW-1:0] LOCK_N     = CW'(LOCK_FRAMES);
   localparam logic [CW-1:0] LOSS_N     = CW'(LOSS_FRAMES);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   cnt_inc;
   logic [6:0]      prev_bits_q, prev_bits_d;
   logic [2:0]      prev_sync_q, prev_sync_d;
   logic            entry_q, entry_d;
   logic [2:0]      lock_phase_q, lock_phase_d;
   logic [7:0]      relock_q, relock_d;
   logic            iq_rst_q, iq_rst_d;
   logic            iq_ce_q, iq_ce_d;
   logic            locked_q, locked_d;
   logic            frame_start_q, frame_start_d;

   logic            frame_tick;
   logic            tick_act;
   logic            amp_ok;
   logic            good_acq;
   logic            bad_lock;

   assign cnt_inc    = cnt_q + 1'b1;
   // A frame boundary is the analyser's bit index wrapping from the last bit
   // to 0. prev_bits is forced to 0 while the analyser is held in reset, so a
   // wrap that straddles a flush is never seen.
   assign frame_tick = (prev_bits_q == LAST_BIT) && (ctrl_if.bits_count == 7'd0);
   // Ticks landing on a state's first cycle belong to the previous state.
   assign tick_act   = frame_tick && !entry_q;
   assign amp_ok     = (ctrl_if.Max_Amp >= ctrl_if.amp_thresh);
   assign good_acq   = (ctrl_if.max_sync == prev_sync_q) && amp_ok;
   assign bad_lock   = !amp_ok || (ctrl_if.max_sync != lock_phase_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lock_phase_d = lock_phase_q;
      relock_d     = relock_q;

      case (state_q)
         S_IDLE: begin
            if (ctrl_if.enable) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end
         end
         S_FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_SETTLE: begin
            if (tick_act) begin
               if (cnt_inc == SETTLE_N) begin
                  state_d = S_ACQUIRE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_ACQUIRE: begin
            if (tick_act) begin
               if (!good_acq) begin
                  cnt_d = '0;
               end else if (cnt_inc == LOCK_N) begin
                  state_d      = S_LOCKED;
                  cnt_d        = '0;
                  lock_phase_d = ctrl_if.max_sync;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_LOCKED: begin
            if (tick_act) begin
               if (!bad_lock) begin
                  cnt_d = '0;
               end else if (cnt_inc == LOSS_N) begin
                  state_d = S_FLUSH;
                  cnt_d   = '0;
                  if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Dropping the run request wins over every other transition, including
      // a lock loss on the same cycle; the loss is then not counted.
      if (!ctrl_if.enable) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         relock_d = relock_q;
      end

      prev_bits_d   = iq_rst_q ? 7'd0 : ctrl_if.bits_count;
      prev_sync_d   = frame_tick ? ctrl_if.max_sync : prev_sync_q;
      entry_d       = (state_d != state_q);
      // Outputs are registered from the next state so they line up with the
      // state register.
      iq_rst_d      = (state_d == S_IDLE) || (state_d == S_FLUSH);
      iq_ce_d       = !iq_rst_d;
      locked_d      = (state_d == S_LOCKED);
      frame_start_d = frame_tick && (state_q == S_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         prev_bits_q   <= '0;
         prev_sync_q   <= '0;
         entry_q       <= 1'b0;
         lock_phase_q  <= '0;
         relock_q      <= '0;
         iq_rst_q      <= 1'b1;
         iq_ce_q       <= 1'b0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         prev_bits_q   <= prev_bits_d;
         prev_sync_q   <= prev_sync_d;
         entry_q       <= entry_d;
         lock_phase_q  <= lock_phase_d;
         relock_q      <= relock_d;
         iq_rst_q      <= iq_rst_d;
         iq_ce_q       <= iq_ce_d;
         locked_q      <= locked_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign ctrl_if.iq_rst       = iq_rst_q;
   assign ctrl_if.iq_ce        = iq_ce_q;
   assign ctrl_if.locked       = locked_q;
   assign ctrl_if.lock_phase   = lock_phase_q;
   assign ctrl_if.frame_start  = frame_start_q;
   assign ctrl_if.state        = state_q;
   assign ctrl_if.relock_count = relock_q;

endmodule
